// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module : serial_sub_pkg
// Brief  : Shared types and constants for the bit-serial subtractor.
//          Holds the FSM state encoding and the default operand width.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

  // Default operand width of the subtractor datapath
  localparam int unsigned SERIAL_SUB_WIDTH_DEFAULT = 8;

  // Controller states: wait for operands, shift bits, present result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of a counter that must reach w-1; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_fs1.sv
// ============================================================================
// Module : full_subtractor_1bit
// Brief  : Combinational one-bit subtractor cell, d = x - y - bi.
//          bo is the borrow propagated to the next more significant bit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module full_subtractor_1bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference bit and borrow-out of a single bit position
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module : serial_subtractor
// Brief  : Bit-serial unsigned subtractor, diff = a - b - bin (mod 2^WIDTH).
//          Operands are captured on a valid/ready handshake, processed one
//          bit per cycle LSB-first through a single full-subtractor cell, and
//          the result is held under a valid/ready output handshake.
//          Optional signed-overflow output enabled by macro SERIAL_SUB_OVF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned          CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [WIDTH-1:0]   a_q;        // minuend, shifted right one bit per cycle
  logic [WIDTH-1:0]   b_q;        // subtrahend, shifted right one bit per cycle
  logic               borrow_q;   // borrow carried into the current bit
  logic [WIDTH-1:0]   res_q;      // partial result, filled from the MSB end
  logic [WIDTH-1:0]   res_d;
  logic [WIDTH-1:0]   diff_q;     // published result, only updated on DONE entry
  logic               bout_q;
  logic               in_ready_q;
  logic               out_valid_q;
`ifdef SERIAL_SUB_OVF_EN
  logic               sign_a_q;   // operand sign bits kept aside, a_q/b_q shift them out
  logic               sign_b_q;
  logic               ovf_q;
`endif

  logic cell_d;
  logic cell_bo;

  // Single shared subtractor cell working on the current LSBs
  full_subtractor_1bit u_cell (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Next partial result and next bit index
  always_comb begin
    res_d = {cell_d, res_q[WIDTH-1:1]};
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Controller and datapath: handshake, bit-serial shifting, result hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      borrow_q    <= 1'b0;
      res_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready is always high here, so in_valid alone completes the handshake
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            borrow_q   <= bin;
            cnt_q      <= '0;
            res_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            sign_a_q   <= a[WIDTH-1];
            sign_b_q   <= b[WIDTH-1];
`endif
          end
        end

        SHIFT: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          borrow_q <= cell_bo;
          res_q    <= res_d;
          cnt_q    <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            // Last bit: the cell's borrow-out is the final borrow of the word
            diff_q      <= res_d;
            bout_q      <= cell_bo;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            // cell_d is the result MSB on this final cycle
            ovf_q       <= (sign_a_q ^ sign_b_q) & (cell_d ^ sign_a_q);
`endif
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module : tb_serial_subtractor
// Brief  : Directed self-checking bench for serial_subtractor (WIDTH=8).
//          ovf checks are compiled in when SERIAL_SUB_OVF_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int n_checks;
  int n_fail;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .diff      (diff),
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation; hold_cycles > 0 keeps out_ready low in DONE while in_valid pulses
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tbin, input logic [7:0] ed, input logic eb,
                        input logic eo, input int hold_cycles);
    int  lat;
    bit  seen;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'hA5; b = 8'h5A; bin = 1'b1;  // scramble inputs to prove they were captured
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) seen = 1;
    end
    // first cycle after the accepting edge is cycle 1, so latency = edges + 1
    check_eq({tag, "_latency"}, lat + 1, WIDTH + 1);
    @(negedge clk);
    check_eq({tag, "_diff"}, diff, ed);
    check_eq({tag, "_bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    check_eq({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("note: %s ovf expectation undefined", tag);
`endif
    for (int i = 0; i < hold_cycles; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 8'h77; b = 8'h11; bin = 1'b0;
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, out_valid, 1);
      check_eq({tag, "_hold_ready"}, in_ready, 0);
      check_eq({tag, "_hold_diff"}, diff, ed);
      check_eq({tag, "_hold_bout"}, bout, eb);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_release_valid"}, out_valid, 0);
    check_eq({tag, "_release_ready"}, in_ready, 1);
    @(negedge clk);
    check_eq({tag, "_idle_diff_kept"}, diff, ed);
  endtask

  logic [7:0] tp_a   [3];
  logic [7:0] tp_b   [3];
  logic       tp_bin [3];
  logic [7:0] tp_d   [3];
  logic       tp_bo  [3];
  logic [7:0] rd     [3];
  logic       rb     [3];
  int         acc    [3];
  int         n_acc;
  int         n_res;
  int         lo_cnt;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_diff", diff, 8'h00);
    check_eq("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    check_eq("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Basic vectors
    run_op("op_5m3",  8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);
    run_op("op_3m5",  8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0);
    run_op("op_0m0b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    // 0x3C - 0x5A - 1 = -31 -> 0xE1, borrow out; result held 5 cycles with in_valid pulsing
    run_op("op_hold", 8'h3C, 8'h5A, 1'b1, 8'hE1, 1'b1, 1'b0, 5);

    // Reset in the middle of SHIFT (during bit 4)
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_diff", diff, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    lo_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!out_valid) lo_cnt++;
    end
    check_eq("abort_no_result", lo_cnt, 12);
    // 0x80 - 0x01 = 0x7F: signs differ and result sign flips -> signed overflow
    run_op("op_post_rst", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);

    // Back-to-back with in_valid and out_ready held high
    tp_a[0] = 8'h10; tp_b[0] = 8'h01; tp_bin[0] = 1'b0; tp_d[0] = 8'h0F; tp_bo[0] = 1'b0;
    tp_a[1] = 8'h01; tp_b[1] = 8'h02; tp_bin[1] = 1'b1; tp_d[1] = 8'hFE; tp_bo[1] = 1'b1;
    tp_a[2] = 8'hFF; tp_b[2] = 8'hFF; tp_bin[2] = 1'b1; tp_d[2] = 8'hFF; tp_bo[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 8'hxx; rb[i] = 1'bx; acc[i] = -1;
    end
    n_acc = 0;
    n_res = 0;
    @(negedge clk);
    a = tp_a[0]; b = tp_b[0]; bin = tp_bin[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && n_res < 3; cyc++) begin
      bit accepting;
      if (cyc > 0) @(negedge clk);
      accepting = in_valid && in_ready;
      if (out_valid && n_res < 3) begin
        rd[n_res] = diff; rb[n_res] = bout; n_res++;
      end
      if (accepting && n_acc < 3) acc[n_acc] = cyc;
      @(posedge clk);
      #1;
      if (accepting) begin
        n_acc++;
        if (n_acc < 3) begin
          a = tp_a[n_acc]; b = tp_b[n_acc]; bin = tp_bin[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_eq("tp_accepts", n_acc, 3);
    check_eq("tp_results", n_res, 3);
    check_eq("tp_gap01", acc[1] - acc[0], WIDTH + 2);
    check_eq("tp_gap12", acc[2] - acc[1], WIDTH + 2);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("tp_diff%0d", i), rd[i], tp_d[i]);
      check_eq($sformatf("tp_bout%0d", i), rb[i], tp_bo[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
